// File: rtl/ysyx_22050039_ctrl_fsm_if.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_22050039_ctrl_fsm_if
//  Purpose  : Handshake bundle between the control sequencer (master) and
//             the instruction fetch unit, mul/div unit and LSU (slave).
//  Revision : 1.0  initial release
// ============================================================================
interface ysyx_22050039_ctrl_fsm_if;
    logic ifu_req;      // instruction fetch request
    logic ifu_rvalid;   // fetched instruction valid
    logic ir_wen;       // latch instruction register
    logic mdu_start;    // single-cycle start pulse to mul/div
    logic mdu_done;     // mul/div result valid
    logic lsu_req;      // data memory request
    logic lsu_we;       // data request is a write
    logic lsu_ack;      // data memory response

    modport master (
        output ifu_req, ir_wen, mdu_start, lsu_req, lsu_we,
        input  ifu_rvalid, mdu_done, lsu_ack
    );

    modport slave (
        input  ifu_req, ir_wen, mdu_start, lsu_req, lsu_we,
        output ifu_rvalid, mdu_done, lsu_ack
    );
endinterface
`default_nettype wire

// File: rtl/ysyx_22050039_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_22050039_ctrl_fsm
//  Purpose  : Multi-cycle control sequencer for the RV64 core. Steps each
//             instruction through FETCH/DECODE/EXEC/(MDU_WAIT|MEM)/WB and
//             reports halt, fatal error and the retired-instruction count.
//  Revision : 1.0  initial release
// ============================================================================
module ysyx_22050039_ctrl_fsm #(
    parameter int XLEN    = 64,
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 5
) (
    input  wire logic                clk,
    input  wire logic                rst,
    ysyx_22050039_ctrl_fsm_if.master bus,
    input  wire logic                i_dec_load,
    input  wire logic                i_dec_store,
    input  wire logic                i_dec_muldiv,
    input  wire logic                i_dec_wpc,
    input  wire logic                i_dec_wreg,
    input  wire logic                i_dec_ebreak,
    input  wire logic                i_dec_invalid,
    output logic                     o_reg_total_wen,
    output logic                     o_pc_update,
    output logic                     o_pc_sel,
    output logic                     o_halt,
    output logic                     o_err,
    output logic [1:0]               o_err_code,
    output logic [2:0]               o_state,
    output logic [XLEN-1:0]          o_instret
);

    localparam logic [2:0] c_fetch    = 3'd0;
    localparam logic [2:0] c_decode   = 3'd1;
    localparam logic [2:0] c_exec     = 3'd2;
    localparam logic [2:0] c_mdu_wait = 3'd3;
    localparam logic [2:0] c_mem      = 3'd4;
    localparam logic [2:0] c_wb       = 3'd5;
    localparam logic [2:0] c_halt     = 3'd6;
    localparam logic [2:0] c_err      = 3'd7;

    localparam logic [1:0] c_ec_fetch = 2'd1;
    localparam logic [1:0] c_ec_mem   = 2'd2;
    localparam logic [1:0] c_ec_dec   = 2'd3;

    // Counter value seen during the last permitted waiting cycle.
    localparam logic [TO_W-1:0] c_to_last = TO_W'(TIMEOUT - 1);

    logic [2:0]      r_state;
    logic [2:0]      w_state_nxt;
    logic [TO_W-1:0] r_to_cnt;
    logic [1:0]      r_err_code;
    logic [1:0]      w_err_code_nxt;
    logic [XLEN-1:0] r_instret;
    logic            w_retire;
    logic            w_dec_bad;
    logic            w_to_expired;

    // An instruction may belong to at most one multi-cycle class.
    assign w_dec_bad = i_dec_invalid
                     | (i_dec_load  & i_dec_store)
                     | (i_dec_load  & i_dec_muldiv)
                     | (i_dec_store & i_dec_muldiv);

    assign w_to_expired = (r_to_cnt == c_to_last);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= c_fetch;
        else     r_state <= w_state_nxt;
    end

    // Wait counter: cleared on any state change so each FETCH/MEM visit starts at 0.
    always_ff @(posedge clk) begin
        if (rst)                                       r_to_cnt <= '0;
        else if (w_state_nxt != r_state)               r_to_cnt <= '0;
        else if (r_state == c_fetch || r_state == c_mem) r_to_cnt <= r_to_cnt + TO_W'(1);
    end

    // Error code is captured once, on the transition into ERR, then held.
    always_ff @(posedge clk) begin
        if (rst)                                          r_err_code <= 2'd0;
        else if (w_state_nxt == c_err && r_state != c_err) r_err_code <= w_err_code_nxt;
    end

    // Retired-instruction counter, wraps naturally at 2^XLEN.
    always_ff @(posedge clk) begin
        if (rst)           r_instret <= '0;
        else if (w_retire) r_instret <= r_instret + XLEN'(1);
    end

    // Next-state, error cause and retire decision.
    always_comb begin
        w_state_nxt    = r_state;
        w_err_code_nxt = 2'd0;
        w_retire       = 1'b0;
        case (r_state)
            c_fetch: begin
                if (bus.ifu_rvalid) begin
                    w_state_nxt = c_decode;
                end else if (w_to_expired) begin
                    w_state_nxt    = c_err;
                    w_err_code_nxt = c_ec_fetch;
                end
            end
            c_decode: begin
                if (w_dec_bad) begin
                    w_state_nxt    = c_err;
                    w_err_code_nxt = c_ec_dec;
                end else if (i_dec_ebreak) begin
                    w_state_nxt = c_halt;
                    w_retire    = 1'b1;
                end else begin
                    w_state_nxt = c_exec;
                end
            end
            c_exec: begin
                if (i_dec_muldiv)                   w_state_nxt = c_mdu_wait;
                else if (i_dec_load || i_dec_store) w_state_nxt = c_mem;
                else                                w_state_nxt = c_wb;
            end
            c_mdu_wait: begin
                if (bus.mdu_done) w_state_nxt = c_wb;
            end
            c_mem: begin
                if (bus.lsu_ack) begin
                    w_state_nxt = c_wb;
                end else if (w_to_expired) begin
                    w_state_nxt    = c_err;
                    w_err_code_nxt = c_ec_mem;
                end
            end
            c_wb: begin
                w_state_nxt = c_fetch;
                w_retire    = 1'b1;
            end
            default: w_state_nxt = r_state;   // HALT and ERR are sticky
        endcase
    end

    // Strobes and status decoded from the current state.
    always_comb begin
        bus.ifu_req     = 1'b0;
        bus.ir_wen      = 1'b0;
        bus.mdu_start   = 1'b0;
        bus.lsu_req     = 1'b0;
        bus.lsu_we      = 1'b0;
        o_reg_total_wen = 1'b0;
        o_pc_update     = 1'b0;
        o_pc_sel        = 1'b0;
        case (r_state)
            c_fetch: begin
                bus.ifu_req = 1'b1;
                bus.ir_wen  = bus.ifu_rvalid;
            end
            c_exec: begin
                bus.mdu_start = i_dec_muldiv;
            end
            c_mem: begin
                bus.lsu_req = 1'b1;
                bus.lsu_we  = i_dec_store;
            end
            c_wb: begin
                o_reg_total_wen = i_dec_wreg;
                o_pc_update     = 1'b1;
                o_pc_sel        = i_dec_wpc;
            end
            default: ;
        endcase
    end

    assign o_halt     = (r_state == c_halt);
    assign o_err      = (r_state == c_err);
    assign o_err_code = r_err_code;
    assign o_state    = r_state;
    assign o_instret  = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22050039_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ysyx_22050039_ctrl_fsm
//  Purpose  : Directed self-checking bench for the control sequencer. A second
//             instance with a 2-bit instret runs in lockstep to show wrapping.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ysyx_22050039_ctrl_fsm;

    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic dl = 0, ds = 0, dm = 0, dwpc = 0, dwreg = 0, deb = 0, dinv = 0;

    logic        reg_total_wen, pc_update, pc_sel, halt, err;
    logic [1:0]  err_code;
    logic [2:0]  state;
    logic [63:0] instret;

    logic        s_wen, s_pcu, s_pcs, s_halt, s_err;
    logic [1:0]  s_ec;
    logic [2:0]  s_state;
    logic [1:0]  s_instret;

    int n_checks = 0;
    int n_errors = 0;
    int n_mds    = 0;

    ysyx_22050039_ctrl_fsm_if u_if ();
    ysyx_22050039_ctrl_fsm_if u_if2 ();

    assign u_if2.ifu_rvalid = u_if.ifu_rvalid;
    assign u_if2.mdu_done   = u_if.mdu_done;
    assign u_if2.lsu_ack    = u_if.lsu_ack;

    ysyx_22050039_ctrl_fsm #(.XLEN(64), .TIMEOUT(TIMEOUT), .TO_W(5)) u_dut (
        .clk(clk), .rst(rst), .bus(u_if),
        .i_dec_load(dl), .i_dec_store(ds), .i_dec_muldiv(dm), .i_dec_wpc(dwpc),
        .i_dec_wreg(dwreg), .i_dec_ebreak(deb), .i_dec_invalid(dinv),
        .o_reg_total_wen(reg_total_wen), .o_pc_update(pc_update), .o_pc_sel(pc_sel),
        .o_halt(halt), .o_err(err), .o_err_code(err_code), .o_state(state),
        .o_instret(instret)
    );

    ysyx_22050039_ctrl_fsm #(.XLEN(2), .TIMEOUT(TIMEOUT), .TO_W(5)) u_dut_small (
        .clk(clk), .rst(rst), .bus(u_if2),
        .i_dec_load(dl), .i_dec_store(ds), .i_dec_muldiv(dm), .i_dec_wpc(dwpc),
        .i_dec_wreg(dwreg), .i_dec_ebreak(deb), .i_dec_invalid(dinv),
        .o_reg_total_wen(s_wen), .o_pc_update(s_pcu), .o_pc_sel(s_pcs),
        .o_halt(s_halt), .o_err(s_err), .o_err_code(s_ec), .o_state(s_state),
        .o_instret(s_instret)
    );

    always #5 clk = ~clk;

    // Count mdu_start pulses seen at clock edges.
    always @(posedge clk) begin
        if (u_if.mdu_start) n_mds <= n_mds + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        u_if.ifu_rvalid = 0; u_if.mdu_done = 0; u_if.lsu_ack = 0;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    // One instruction: rvalid in fetch cycle fw, response in wait cycle nw.
    // fw/nw beyond TIMEOUT mean the response never comes.
    task automatic run(input logic ld, st, md, wpc, wreg, eb, inv,
                       input int fw, input int nw, input int exp_lat);
        int lat;
        int mds0;
        dl = ld; ds = st; dm = md; dwpc = wpc; dwreg = wreg; deb = eb; dinv = inv;
        mds0 = n_mds;
        lat  = 0;
        for (int i = 1; i <= fw && i <= TIMEOUT; i++) begin
            u_if.ifu_rvalid = (i == fw);
            #1;
            chk("fetch_state", state, 0);
            chk("ifu_req", u_if.ifu_req, 1);
            if (i == fw) chk("ir_wen", u_if.ir_wen, 1);
            cycle(); lat++;
        end
        u_if.ifu_rvalid = 0;
        if (fw > TIMEOUT) begin
            #1;
            chk("fetch_to_state", state, 7);
            chk("fetch_to_err", err, 1);
            chk("fetch_to_code", err_code, 1);
            chk("fetch_to_req", u_if.ifu_req, 0);
            return;
        end
        #1;
        chk("decode_state", state, 1);
        chk("decode_irwen", u_if.ir_wen, 0);
        cycle(); lat++;
        if (inv || (ld && st) || (ld && md) || (st && md)) begin
            #1;
            chk("illegal_state", state, 7);
            chk("illegal_code", err_code, 3);
            chk("illegal_err", err, 1);
            return;
        end
        if (eb) begin
            #1;
            chk("ebreak_state", state, 6);
            chk("ebreak_halt", halt, 1);
            return;
        end
        u_if.mdu_done = md;   // must be ignored during EXEC
        #1;
        chk("exec_state", state, 2);
        chk("exec_mdu_start", u_if.mdu_start, md);
        cycle(); lat++;
        u_if.mdu_done = 0;
        if (md) begin
            for (int i = 1; i <= nw; i++) begin
                u_if.mdu_done = (i == nw);
                #1;
                chk("mdu_state", state, 3);
                chk("mdu_start_low", u_if.mdu_start, 0);
                cycle(); lat++;
            end
            u_if.mdu_done = 0;
        end else if (ld || st) begin
            for (int i = 1; i <= nw && i <= TIMEOUT; i++) begin
                u_if.lsu_ack = (i == nw);
                #1;
                chk("mem_state", state, 4);
                chk("lsu_req", u_if.lsu_req, 1);
                chk("lsu_we", u_if.lsu_we, st);
                cycle(); lat++;
            end
            u_if.lsu_ack = 0;
            if (nw > TIMEOUT) begin
                #1;
                chk("mem_to_state", state, 7);
                chk("mem_to_code", err_code, 2);
                chk("mem_to_req", u_if.lsu_req, 0);
                return;
            end
        end
        lat++;
        #1;
        chk("wb_state", state, 5);
        chk("wb_reg_wen", reg_total_wen, wreg);
        chk("wb_pc_update", pc_update, 1);
        chk("wb_pc_sel", pc_sel, wpc);
        chk("latency", lat, exp_lat);
        cycle();
        #1;
        chk("post_wb_state", state, 0);
        chk("post_wb_pc_update", pc_update, 0);
        chk("mdu_pulses", n_mds - mds0, md);
    endtask

    initial begin
        u_if.ifu_rvalid = 0; u_if.mdu_done = 0; u_if.lsu_ack = 0;
        rst = 1'b1;
        cycle();
        cycle();
        chk("rst_state", state, 0);
        chk("rst_instret", instret, 0);
        chk("rst_err", err, 0);
        chk("rst_halt", halt, 0);
        chk("rst_err_code", err_code, 0);
        chk("rst_lsu_req", u_if.lsu_req, 0);
        chk("rst_mdu_start", u_if.mdu_start, 0);
        chk("rst_reg_wen", reg_total_wen, 0);
        chk("rst_pc_update", pc_update, 0);
        chk("rst_ir_wen", u_if.ir_wen, 0);
        rst = 1'b0;

        //  ld st md wpc wreg eb inv  fw  nw  lat
        run(0, 0, 0, 0, 1, 0, 0,  1,  0,  4);   // addi
        chk("instret_addi", instret, 1);
        run(1, 0, 0, 0, 1, 0, 0,  1,  3,  7);   // ld, ack in 3rd MEM cycle
        run(0, 1, 0, 0, 0, 0, 0,  1,  1,  5);   // sd
        run(0, 0, 0, 1, 0, 0, 0,  1,  0,  4);   // beq taken
        run(0, 0, 1, 0, 1, 0, 0,  1,  7, 11);   // mulw, done 7 cycles after EXEC
        chk("instret_after_mul", instret, 5);
        run(1, 0, 0, 0, 1, 0, 0,  1, 16, 20);   // ack on last allowed MEM cycle
        run(0, 0, 0, 0, 1, 0, 0, 16,  0, 19);   // rvalid on last allowed FETCH cycle
        chk("instret_boundary", instret, 7);

        run(1, 0, 0, 0, 1, 0, 0,  1, 17,  0);   // MEM timeout
        u_if.lsu_ack = 1; u_if.ifu_rvalid = 1;
        cycle(); cycle(); cycle();
        chk("err_sticky_state", state, 7);
        chk("err_sticky_code", err_code, 2);
        chk("err_frozen_instret", instret, 7);
        chk("err_no_req", u_if.ifu_req, 0);
        do_reset();
        chk("reset_clears_instret", instret, 0);

        run(0, 0, 0, 0, 1, 0, 0, 17,  0,  0);   // fetch timeout
        do_reset();
        run(0, 0, 0, 0, 1, 0, 1,  1,  0,  0);   // invalid decode
        do_reset();
        run(1, 1, 0, 0, 1, 0, 0,  1,  0,  0);   // load+store conflict
        do_reset();

        run(0, 0, 0, 0, 1, 0, 0,  1,  0,  4);
        run(0, 0, 0, 0, 0, 1, 0,  1,  0,  0);   // ebreak
        chk("ebreak_instret", instret, 2);
        u_if.ifu_rvalid = 1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            chk("halt_state", state, 6);
            chk("halt_no_req", u_if.ifu_req, 0);
        end
        chk("halt_instret", instret, 2);
        chk("halt_err", err, 0);
        do_reset();

        // Reset in the middle of a memory access.
        run(0, 0, 0, 0, 1, 0, 0,  1,  0,  4);
        dl = 1; ds = 0; dm = 0; dwpc = 0; dwreg = 1; deb = 0; dinv = 0;
        u_if.ifu_rvalid = 1;
        cycle();
        u_if.ifu_rvalid = 0;
        cycle();
        cycle();
        chk("mid_mem_state", state, 4);
        chk("mid_mem_req", u_if.lsu_req, 1);
        rst = 1'b1;
        cycle();
        chk("rst_mem_state", state, 0);
        chk("rst_mem_req", u_if.lsu_req, 0);
        chk("rst_mem_instret", instret, 0);
        chk("rst_mem_err", err, 0);
        rst = 1'b0;

        // Counter wrap on the 2-bit instance.
        run(0, 0, 0, 0, 1, 0, 0,  1,  0,  4);
        run(0, 0, 0, 0, 1, 0, 0,  1,  0,  4);
        run(0, 0, 0, 0, 1, 0, 0,  1,  0,  4);
        chk("small_instret_max", s_instret, 3);
        run(0, 0, 0, 0, 1, 0, 0,  1,  0,  4);
        chk("small_instret_wrap", s_instret, 0);
        chk("big_instret", instret, 4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
